// File: rtl/analog_anneal_ctrl.sv
// analog_anneal_ctrl
//   Sequencer for one annealing run on the analog Ising macro. It programs the
//   TX synchronizer, pulses macro_start_o once per iteration and collects each
//   synchronized spin vector into a one-entry output buffer. It also counts
//   iterations and enforces a per-iteration timeout.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   en_i                       block enable; low forces IDLE and empties the buffer
//   start_i                    run request, accepted in IDLE only
//   num_iter_i                 iterations per run (latched at start)
//   timeout_cycles_i           max unstalled WAIT cycles per iteration, 0 = off
//   pipe_num_i, sync_mode_i    synchronizer settings (latched at start)
//   tx_configure_enable_o      one-cycle TX config strobe
//   synchronizer_pipe_num_o    latched pipe_num
//   synchronizer_mode_o        latched sync mode
//   macro_start_o              one-cycle compute-start pulse
//   tx_spin_valid_i/_ready_o   spin handshake from the TX synchronizer
//   tx_spin_i                  spin vector from TX
//   spin_valid_o/spin_ready_i  buffered spin handshake to the digital side
//   spin_o                     buffered spin vector (holds after drain)
//   iter_cnt_o                 iterations completed in the current run
//   busy_o                     FSM not in IDLE
//   done_o                     one-cycle end-of-run pulse
//   timeout_o                  sticky timeout flag, cleared by the next start
module analog_anneal_ctrl #(
  parameter int NUM_SPIN               = 256,
  parameter int SYNCHRONIZER_PIPEDEPTH = 3,
  parameter int ITER_W                 = 16,
  parameter int TIMEOUT_W              = 16,
  localparam int PW = (SYNCHRONIZER_PIPEDEPTH > 1) ? $clog2(SYNCHRONIZER_PIPEDEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic [ITER_W-1:0]    num_iter_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic [PW-1:0]        pipe_num_i,
  input  logic                 sync_mode_i,
  output logic                 tx_configure_enable_o,
  output logic [PW-1:0]        synchronizer_pipe_num_o,
  output logic                 synchronizer_mode_o,
  output logic                 macro_start_o,
  input  logic                 tx_spin_valid_i,
  output logic                 tx_spin_ready_o,
  input  logic [NUM_SPIN-1:0]  tx_spin_i,
  output logic                 spin_valid_o,
  input  logic                 spin_ready_i,
  output logic [NUM_SPIN-1:0]  spin_o,
  output logic [ITER_W-1:0]    iter_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;

  logic [ITER_W-1:0]    num_iter_q;
  logic [TIMEOUT_W-1:0] tmo_cfg_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic [PW-1:0]        pipe_q;
  logic                 mode_q;
  logic [ITER_W-1:0]    iter_cnt_q;
  logic                 timeout_q;
  logic                 spin_valid_q;
  logic [NUM_SPIN-1:0]  spin_q;

  logic                 accept_start;
  logic                 tx_hs;
  logic                 expire;
  logic                 last_iter;
  logic [ITER_W-1:0]    iter_inc;

  // Decoded outputs
  assign tx_configure_enable_o   = (state_q == ST_CONFIG);
  assign macro_start_o           = (state_q == ST_LAUNCH);
  assign tx_spin_ready_o         = (state_q == ST_WAIT) && !spin_valid_q;
  assign busy_o                  = (state_q != ST_IDLE);
  // The buffer is always empty by the time DONE is left, so done_o marks the
  // cycle DONE first sees it empty.
  assign done_o                  = (state_q == ST_DONE) && !spin_valid_q;

  assign synchronizer_pipe_num_o = pipe_q;
  assign synchronizer_mode_o     = mode_q;
  assign spin_valid_o            = spin_valid_q;
  assign spin_o                  = spin_q;
  assign iter_cnt_o              = iter_cnt_q;
  assign timeout_o               = timeout_q;

  assign accept_start = (state_q == ST_IDLE) && en_i && start_i;
  // A transfer offered while en_i is low is dropped so iter_cnt holds.
  assign tx_hs        = tx_spin_ready_o && tx_spin_valid_i && en_i;
  assign iter_inc     = iter_cnt_q + 1'b1;
  assign last_iter    = (iter_inc == num_iter_q);
  // The counter is loaded in LAUNCH and only moves while ready is high, so the
  // value 1 in an unstalled WAIT cycle means this is the final allowed cycle.
  // A handshake in that same cycle takes priority.
  assign expire       = en_i && tx_spin_ready_o && (tmo_cfg_q != '0) &&
                        (tmo_cnt_q == TIMEOUT_W'(1)) && !tx_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_CONFIG;
      ST_CONFIG: state_d = (num_iter_q == '0) ? ST_DONE : ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_hs) begin
          state_d = last_iter ? ST_DONE : ST_LAUNCH;
        end else if (expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   if (!spin_valid_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!en_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_iter_q   <= '0;
      tmo_cfg_q    <= '0;
      tmo_cnt_q    <= '0;
      pipe_q       <= '0;
      mode_q       <= 1'b0;
      iter_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      spin_valid_q <= 1'b0;
      spin_q       <= '0;
    end else begin
      if (accept_start) begin
        num_iter_q <= num_iter_i;
        tmo_cfg_q  <= timeout_cycles_i;
        pipe_q     <= pipe_num_i;
        mode_q     <= sync_mode_i;
        iter_cnt_q <= '0;
        timeout_q  <= 1'b0;
      end

      if (state_q == ST_LAUNCH) begin
        tmo_cnt_q <= tmo_cfg_q;
      end else if (tx_spin_ready_o && (tmo_cnt_q != '0)) begin
        tmo_cnt_q <= tmo_cnt_q - 1'b1;
      end

      if (tx_hs) begin
        spin_q     <= tx_spin_i;
        iter_cnt_q <= iter_inc;
      end

      if (expire) begin
        timeout_q <= 1'b1;
      end

      if (!en_i) begin
        spin_valid_q <= 1'b0;
      end else if (tx_hs) begin
        spin_valid_q <= 1'b1;
      end else if (spin_valid_q && spin_ready_i) begin
        spin_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_analog_anneal_ctrl.sv
module tb_analog_anneal_ctrl;

  localparam int NS = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          start_i;
  logic [15:0]   num_iter_i;
  logic [15:0]   timeout_cycles_i;
  logic [1:0]    pipe_num_i;
  logic          sync_mode_i;
  logic          tx_configure_enable_o;
  logic [1:0]    synchronizer_pipe_num_o;
  logic          synchronizer_mode_o;
  logic          macro_start_o;
  logic          tx_spin_valid_i;
  logic          tx_spin_ready_o;
  logic [NS-1:0] tx_spin_i;
  logic          spin_valid_o;
  logic          spin_ready_i;
  logic [NS-1:0] spin_o;
  logic [15:0]   iter_cnt_o;
  logic          busy_o;
  logic          done_o;
  logic          timeout_o;

  analog_anneal_ctrl #(
    .NUM_SPIN(NS),
    .SYNCHRONIZER_PIPEDEPTH(3),
    .ITER_W(16),
    .TIMEOUT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .start_i(start_i),
    .num_iter_i(num_iter_i),
    .timeout_cycles_i(timeout_cycles_i),
    .pipe_num_i(pipe_num_i),
    .sync_mode_i(sync_mode_i),
    .tx_configure_enable_o(tx_configure_enable_o),
    .synchronizer_pipe_num_o(synchronizer_pipe_num_o),
    .synchronizer_mode_o(synchronizer_mode_o),
    .macro_start_o(macro_start_o),
    .tx_spin_valid_i(tx_spin_valid_i),
    .tx_spin_ready_o(tx_spin_ready_o),
    .tx_spin_i(tx_spin_i),
    .spin_valid_o(spin_valid_o),
    .spin_ready_i(spin_ready_i),
    .spin_o(spin_o),
    .iter_cnt_o(iter_cnt_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NS-1:0] sb[$];

  typedef struct {
    int num_iter;
    int tmo;
    int pipe;
    int mode;
    int delay;     // cycles from macro_start_o to TX valid; -1 = never
    int stall;     // spin_ready_i low this many cycles after the first capture
    int exp_macro;
    int exp_iter;
    int exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c, last_m, last_hs, t_rise, n_macro, n_cfg, done_c, stall_left, viol, n_out, exp_done;
    bit pending, seen_done, first_hs;
    logic [NS-1:0] last_spin, exp_spin;
    last_m = 0; last_hs = 0; t_rise = -1; n_macro = 0; n_cfg = 0; done_c = -1;
    stall_left = 0; viol = 0; n_out = 0; pending = 0; seen_done = 0; first_hs = 1;
    last_spin = '0;
    en_i = 1; start_i = 1; spin_ready_i = 1; tx_spin_valid_i = 0;
    num_iter_i = 16'(v.num_iter); timeout_cycles_i = 16'(v.tmo);
    pipe_num_i = 2'(v.pipe); sync_mode_i = v.mode[0];
    step();
    c = 1;
    start_i = 0;
    // Scramble config inputs: the DUT must use its latched copies.
    num_iter_i = 16'($urandom); timeout_cycles_i = 16'($urandom);
    pipe_num_i = 2'($urandom); sync_mode_i = 1'($urandom);
    while (!seen_done && c < 400) begin
      if (!pending) tx_spin_valid_i = 0;
      if (c == 1) begin
        check($sformatf("v%0d_timeout_clr", idx), timeout_o, 0);
        check($sformatf("v%0d_iter_clr", idx), iter_cnt_o, 0);
      end
      if (tx_configure_enable_o) begin
        n_cfg++;
        check($sformatf("v%0d_cfg_cycle", idx), c, 1);
        check($sformatf("v%0d_pipe_o", idx), synchronizer_pipe_num_o, v.pipe);
        check($sformatf("v%0d_mode_o", idx), synchronizer_mode_o, v.mode);
      end
      if (macro_start_o) begin
        n_macro++;
        check($sformatf("v%0d_macro_cycle", idx), c, (n_macro == 1) ? 2 : last_hs + 1);
        last_m = c;
        pending = 1;
      end
      if (timeout_o && t_rise < 0) t_rise = c;
      if (done_o) begin
        seen_done = 1;
        done_c = c;
      end
      if (spin_valid_o && tx_spin_ready_o) viol++;
      spin_ready_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (pending && v.delay >= 0 && c >= last_m + v.delay && !tx_spin_valid_i) begin
        tx_spin_valid_i = 1;
        tx_spin_i = NS'($urandom);
      end
      if (tx_spin_valid_i && tx_spin_ready_o) begin
        sb.push_back(tx_spin_i);
        pending = 0;
        last_hs = c;
        if (first_hs) stall_left = v.stall;
        first_hs = 0;
      end
      if (spin_valid_o && spin_ready_i) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL v%0d_sb_unexpected: got %0h expected none", idx, spin_o);
        end else begin
          exp_spin = sb.pop_front();
          check($sformatf("v%0d_spin_out", idx), spin_o, exp_spin);
          last_spin = exp_spin;
          n_out++;
        end
      end
      step();
      c++;
    end
    tx_spin_valid_i = 0;
    check($sformatf("v%0d_done_seen", idx), seen_done, 1);
    if (v.exp_to != 0) exp_done = t_rise;
    else if (v.num_iter == 0) exp_done = 2;
    else exp_done = last_hs + 2;
    check($sformatf("v%0d_done_cycle", idx), done_c, exp_done);
    check($sformatf("v%0d_cfg_count", idx), n_cfg, 1);
    check($sformatf("v%0d_macro_count", idx), n_macro, v.exp_macro);
    check($sformatf("v%0d_iter_cnt", idx), iter_cnt_o, v.exp_iter);
    check($sformatf("v%0d_timeout", idx), timeout_o, v.exp_to);
    check($sformatf("v%0d_spins_out", idx), n_out, v.exp_iter);
    check($sformatf("v%0d_sb_left", idx), sb.size(), 0);
    check($sformatf("v%0d_ready_while_full", idx), viol, 0);
    check($sformatf("v%0d_done_pulse", idx), done_o, 0);
    check($sformatf("v%0d_idle", idx), busy_o, 0);
    if (v.exp_to != 0) check($sformatf("v%0d_to_latency", idx), t_rise - last_m, v.tmo + 1);
    if (v.exp_iter != 0) check($sformatf("v%0d_spin_hold", idx), spin_o, last_spin);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] hold_spin;
    //          iter tmo pipe mode dly stall macro iter to
    vecs[0] = '{3,   0,  1,   0,   5,  0,    3,    3,   0};
    vecs[1] = '{0,   0,  2,   1,   2,  0,    0,    0,   0};
    vecs[2] = '{2,   4,  0,   0,  -1,  0,    1,    0,   1};
    vecs[3] = '{2,   4,  3,   1,   4,  0,    2,    2,   0};
    vecs[4] = '{2,   4,  1,   1,   5,  0,    1,    0,   1};
    vecs[5] = '{1,   1,  2,   0,   1,  0,    1,    1,   0};
    vecs[6] = '{1,   1,  0,   1,   2,  0,    1,    0,   1};
    vecs[7] = '{2,   8,  2,   1,   2,  20,   2,    2,   0};
    vecs[8] = '{4,   0,  1,   0,   1,  0,    4,    4,   0};

    rst_ni = 0; en_i = 0; start_i = 0; num_iter_i = '0; timeout_cycles_i = '0;
    pipe_num_i = '0; sync_mode_i = 0; tx_spin_valid_i = 0; tx_spin_i = '0; spin_ready_i = 0;
    step(); step();
    check("rst_busy", busy_o, 0);
    check("rst_outputs", {tx_configure_enable_o, macro_start_o, tx_spin_ready_o, spin_valid_o,
                          done_o, timeout_o, synchronizer_mode_o, synchronizer_pipe_num_o}, 0);
    check("rst_iter", iter_cnt_o, 0);
    check("rst_spin", spin_o, 0);
    rst_ni = 1;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // en_i dropped in WAIT with the buffer full; start_i while busy is ignored.
    en_i = 1; start_i = 1; num_iter_i = 2; timeout_cycles_i = 0; pipe_num_i = 1;
    sync_mode_i = 0; spin_ready_i = 0;
    step();                       // cycle 1: CONFIG
    start_i = 0;
    check("en_cfg", tx_configure_enable_o, 1);
    step();                       // cycle 2: LAUNCH
    check("en_macro", macro_start_o, 1);
    step();                       // cycle 3: WAIT, handshake here
    tx_spin_valid_i = 1; tx_spin_i = NS'($urandom);
    check("en_ready", tx_spin_ready_o, 1);
    step();                       // cycle 4: LAUNCH, buffer full
    tx_spin_valid_i = 0;
    check("en_buf_full", spin_valid_o, 1);
    check("en_iter1", iter_cnt_o, 1);
    start_i = 1;
    step();                       // cycle 5: WAIT, stalled
    start_i = 0;
    check("en_start_ignored", tx_configure_enable_o, 0);
    check("en_wait_busy", busy_o, 1);
    en_i = 0;
    step();                       // cycle 6: forced IDLE
    check("en_off_idle", busy_o, 0);
    check("en_off_buf", spin_valid_o, 0);
    check("en_off_done", done_o, 0);
    check("en_off_iter_hold", iter_cnt_o, 1);
    step();
    check("en_off_done2", done_o, 0);
    check("en_off_stays_idle", busy_o, 0);
    en_i = 1;
    step();

    // Asynchronous reset in the middle of WAIT.
    start_i = 1; num_iter_i = 2; timeout_cycles_i = 0; pipe_num_i = 3; sync_mode_i = 1;
    spin_ready_i = 0;
    step(); start_i = 0;          // CONFIG
    step();                       // LAUNCH
    step();                       // WAIT
    tx_spin_valid_i = 1; tx_spin_i = NS'($urandom); hold_spin = tx_spin_i;
    step();                       // LAUNCH, buffer full
    tx_spin_valid_i = 0;
    check("ar_pre_spin", spin_o, hold_spin);
    step();                       // WAIT
    check("ar_pre_busy", busy_o, 1);
    #2 rst_ni = 0;
    #1;
    check("ar_busy", busy_o, 0);
    check("ar_outputs", {tx_configure_enable_o, macro_start_o, tx_spin_ready_o, spin_valid_o,
                         done_o, timeout_o, synchronizer_mode_o, synchronizer_pipe_num_o}, 0);
    check("ar_iter", iter_cnt_o, 0);
    check("ar_spin", spin_o, 0);
    step();
    rst_ni = 1;
    spin_ready_i = 1;
    step();
    run_vec(vecs[0], 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
